// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry register process
// WIDTH-bit operands LSB first, with valid/ready handshakes on both sides.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic s_bit;
  logic c_next;

  assign s_bit  = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          c_d     = sub | cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d             = a_q >> 1;
        b_d             = b_q >> 1;
        c_d             = c_next;
        sr_d            = sr_q >> 1;
        sr_d[WIDTH-1]   = s_bit;
        cnt_d           = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // c_q is the carry into the MSB on this final step.
          sum_d   = sr_d;
          carry_d = c_next;
          ovf_d   = c_q ^ c_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = !rst && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder at WIDTH 8, 4 and 1, sharing
// one clock and reset; one instance is exercised at a time.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] op_a = '0, op_b = '0;
  logic       op_sub = 1'b0, op_cin = 1'b0;
  logic [2:0] in_valid_v = '0;
  logic       out_ready = 1'b1;
  int         sel = 0;

  logic       rdy8, rdy4, rdy1, vld8, vld4, vld1;
  logic [7:0] sum8;
  logic [3:0] sum4;
  logic [0:0] sum1;
  logic       c8, c4, c1, v8, v4, v1;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(rdy8),
    .a(op_a), .b(op_b), .sub(op_sub), .cin(op_cin),
    .out_valid(vld8), .out_ready(out_ready), .sum(sum8), .carry(c8), .overflow(v8));

  serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(rdy4),
    .a(op_a[3:0]), .b(op_b[3:0]), .sub(op_sub), .cin(op_cin),
    .out_valid(vld4), .out_ready(out_ready), .sum(sum4), .carry(c4), .overflow(v4));

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(rdy1),
    .a(op_a[0:0]), .b(op_b[0:0]), .sub(op_sub), .cin(op_cin),
    .out_valid(vld1), .out_ready(out_ready), .sum(sum1), .carry(c1), .overflow(v1));

  logic       g_ready, g_valid, g_carry, g_ovf;
  logic [7:0] g_sum;

  always_comb begin
    g_ready = rdy8; g_valid = vld8; g_sum = sum8; g_carry = c8; g_ovf = v8;
    if (sel == 1) begin
      g_ready = rdy4; g_valid = vld4; g_sum = {4'b0, sum4}; g_carry = c4; g_ovf = v4;
    end else if (sel == 2) begin
      g_ready = rdy1; g_valid = vld1; g_sum = {7'b0, sum1}; g_carry = c1; g_ovf = v1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent arithmetic model: {overflow, carry, sum} for a WIDTH=w operation.
  function automatic logic [9:0] ref_model(input int w, input int av, input int bv,
                                           input bit s, input bit ci);
    int mask, bb, tot, sm;
    bit sa, sb, ss;
    mask = (1 << w) - 1;
    bb   = s ? (~bv & mask) : (bv & mask);
    tot  = (av & mask) + bb + (s ? 1 : int'(ci));
    sm   = tot & mask;
    sa   = 1'((av >> (w - 1)) & 1);
    sb   = 1'((bb >> (w - 1)) & 1);
    ss   = 1'((sm >> (w - 1)) & 1);
    return {(sa == sb) && (ss != sa), 1'((tot >> w) & 1), 8'(sm)};
  endfunction

  // One full operation on instance w_sel (0:W8, 1:W4, 2:W1), with optional
  // operand churn during RUN and optional 5-cycle backpressure in DONE.
  task automatic do_op(input int w_sel, input int w, input logic [7:0] av, input logic [7:0] bv,
                       input bit s, input bit ci, input logic [7:0] es, input bit ec,
                       input bit ev, input string tag, input bit hold_valid, input bit bp);
    int n;
    sel = w_sel;
    out_ready = !bp;
    n = 0;
    while (!g_ready && n < 20) begin tick(); n++; end
    check({tag, " in_ready idle"}, 64'(g_ready), 64'd1);
    op_a = av; op_b = bv; op_sub = s; op_cin = ci;
    in_valid_v = 3'b001 << w_sel;
    tick();
    if (!hold_valid) in_valid_v = '0;
    n = 0;
    while (!g_valid && n < 20) begin
      if (hold_valid) begin
        op_a = av ^ 8'hA5; op_b = bv ^ 8'h3C; op_sub = !s;
        check({tag, " in_ready run"}, 64'(g_ready), 64'd0);
      end
      tick();
      n++;
    end
    in_valid_v = '0;
    check({tag, " latency"}, 64'(n), 64'(w));
    check({tag, " sum"}, 64'(g_sum), 64'(es));
    check({tag, " carry"}, 64'(g_carry), 64'(ec));
    check({tag, " ovf"}, 64'(g_ovf), 64'(ev));
    if (bp) begin
      for (int i = 0; i < 5; i++) begin
        tick();
        check({tag, " bp valid"}, 64'(g_valid), 64'd1);
        check({tag, " bp outs"}, {55'd0, g_ovf, g_carry, g_sum}, {55'd0, ev, ec, es});
      end
      out_ready = 1'b1;
    end
    tick();
    check({tag, " handoff"}, 64'(g_valid), 64'd0);
    check({tag, " held sum"}, 64'(g_sum), 64'(es));
  endtask

  initial begin
    logic [9:0] r;
    repeat (3) tick();
    sel = 0;
    check("rst in_ready", 64'(rdy8), 64'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 64'(rdy8), 64'd1);
    check("post-rst out_valid", 64'(vld8), 64'd0);
    check("post-rst sum", 64'(sum8), 64'h00);
    check("post-rst carry", 64'(c8), 64'd0);
    tick();

    do_op(0, 8, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add0F01", 1'b0, 1'b0);
    do_op(0, 8, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "addFF01", 1'b0, 1'b0);
    do_op(0, 8, 8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, "add7Fcin", 1'b0, 1'b0);
    do_op(0, 8, 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, "sub0507", 1'b0, 1'b0);
    do_op(0, 8, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, "sub8001", 1'b0, 1'b0);
    do_op(0, 8, 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "holdvalid", 1'b1, 1'b0);
    do_op(0, 8, 8'hC8, 8'h64, 1'b0, 1'b1, 8'h2D, 1'b1, 1'b0, "backpress", 1'b0, 1'b1);

    // Reset during RUN bit 3 abandons the operation.
    sel = 0;
    op_a = 8'hFF; op_b = 8'hFF; op_sub = 1'b0; op_cin = 1'b1;
    in_valid_v = 3'b001;
    tick();
    in_valid_v = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst out_valid", 64'(vld8), 64'd0);
    check("midrst in_ready", 64'(rdy8), 64'd0);
    check("midrst sum", 64'(sum8), 64'h00);
    rst = 1'b0;
    #1;
    check("midrst idle", 64'(rdy8), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("midrst no stale", 64'(vld8), 64'd0);
    end
    do_op(0, 8, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "after rst", 1'b0, 1'b0);

    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int s = 0; s < 2; s++)
          for (int ci = 0; ci < 2; ci++) begin
            r = ref_model(4, av, bv, s[0], ci[0]);
            do_op(1, 4, 8'(av), 8'(bv), s[0], ci[0], r[7:0], r[8], r[9],
                  $sformatf("w4 a%0d b%0d s%0d c%0d", av, bv, s, ci), 1'b0, 1'b0);
          end

    for (int av = 0; av < 2; av++)
      for (int bv = 0; bv < 2; bv++)
        for (int s = 0; s < 2; s++)
          for (int ci = 0; ci < 2; ci++) begin
            r = ref_model(1, av, bv, s[0], ci[0]);
            do_op(2, 1, 8'(av), 8'(bv), s[0], ci[0], r[7:0], r[8], r[9],
                  $sformatf("w1 a%0d b%0d s%0d c%0d", av, bv, s, ci), 1'b0, 1'b0);
          end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
